// File: rtl/mant_div_24bit_pkg.sv
// Package: mant_div_24bit_pkg
// Shared definitions for the sequential mantissa divider.
//   MW_DEF  : default mantissa width, hidden bit included
//   QW_DEF  : default quotient width (1 integer bit + MW+1 fraction bits)
//   state_t : divider FSM state encoding (IDLE / RUN / DONE)
package mant_div_24bit_pkg;

   localparam int MW_DEF = 24;
   localparam int QW_DEF = MW_DEF + 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mant_div_24bit_step.sv
// Module: mant_div_24bit_step
// One restoring-division step. It is purely combinational.
// The remainder is compared against the divisor by trial subtraction.
// The result is either the difference or the restored remainder, shifted left by one.
// Ports:
//   rem      in  W  current partial remainder
//   div      in  W  divisor, zero-extended to W bits
//   qbit     out 1  quotient bit (1 when rem >= div)
//   rem_next out W  next partial remainder, already shifted left by one
module mant_div_24bit_step #(
   parameter int W = 26
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] div,
   output logic         qbit,
   output logic [W-1:0] rem_next
);

   logic [W:0]   carry;
   logic [W-1:0] diff;

   // rem - div is computed as rem + ~div + 1 on a ripple chain of full adders.
   // A carry out of the top bit means no borrow, so rem >= div.
   assign carry[0] = 1'b1;

   for (genvar i = 0; i < W; i++) begin : g_fa
      logic x, y;
      assign x           = rem[i];
      assign y           = ~div[i];
      assign diff[i]     = x ^ y ^ carry[i];
      assign carry[i+1]  = (x & y) | (carry[i] & (x ^ y));
   end

   assign qbit     = carry[W];
   assign rem_next = qbit ? {diff[W-2:0], 1'b0} : {rem[W-2:0], 1'b0};

endmodule

// File: rtl/mant_div_24bit.sv
// Module: mant_div_24bit
// Sequential restoring radix-2 mantissa divider that produces one quotient bit per clock.
// It computes q = floor(a * 2^(MW+1) / b) for normalized mantissas in [1,2).
// The sticky bit flags a nonzero final remainder for the downstream rounding stage.
// When b == 0, q is all ones, sticky = 1 and div_zero = 1, and done follows the accepting edge.
// Build option:
//   DIV_EARLY_TERM_EN : finish as soon as the partial remainder becomes zero.
//                       The remaining low quotient bits are zero-filled.
// Ports:
//   clk      in  1   clock, rising edge
//   rst_n    in  1   asynchronous active-low reset
//   start    in  1   start request, sampled only when not busy
//   a        in  MW  dividend mantissa
//   b        in  MW  divisor mantissa
//   busy     out 1   high while dividing
//   done     out 1   one-cycle completion pulse
//   q        out QW  quotient, held until the next accepted start
//   sticky   out 1   final remainder nonzero
//   div_zero out 1   divisor was zero
module mant_div_24bit
   import mant_div_24bit_pkg::*;
#(
   parameter int MW = MW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [MW-1:0]   a,
   input  logic [MW-1:0]   b,
   output logic            busy,
   output logic            done,
   output logic [MW+1:0]   q,
   output logic            sticky,
   output logic            div_zero
);

   localparam int QW = MW + 2;
   localparam int RW = MW + 2;
   localparam int CW = $clog2(QW);

   state_t          state, state_next;
   logic [RW-1:0]   rem;
   logic [MW-1:0]   div;
   logic [CW-1:0]   cnt;

   logic            accept;
   logic            finish;
   logic            qbit;
   logic [RW-1:0]   rem_next;
   logic [QW-1:0]   q_shift;
   logic            early_zero;

   mant_div_24bit_step #(.W(RW)) u_step (
      .rem      (rem),
      .div      ({2'b00, div}),
      .qbit     (qbit),
      .rem_next (rem_next)
   );

   assign q_shift = {q[QW-2:0], qbit};

`ifdef DIV_EARLY_TERM_EN
   assign early_zero = (rem_next == '0);
`else
   assign early_zero = 1'b0;
`endif

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state logic.
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      finish     = 1'b0;
      unique case (state)
         S_IDLE, S_DONE: begin
            state_next = S_IDLE;
            if (start) begin
               accept     = 1'b1;
               state_next = (b == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (cnt == '0 || early_zero) begin
               finish     = 1'b1;
               state_next = S_DONE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath: remainder, divisor, bit counter, quotient and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem      <= '0;
         div      <= '0;
         cnt      <= '0;
         q        <= '0;
         sticky   <= 1'b0;
         div_zero <= 1'b0;
      end else if (accept) begin
         if (b == '0) begin
            q        <= '1;
            sticky   <= 1'b1;
            div_zero <= 1'b1;
         end else begin
            rem      <= {2'b00, a};
            div      <= b;
            cnt      <= CW'(QW - 1);
            q        <= '0;
            sticky   <= 1'b0;
            div_zero <= 1'b0;
         end
      end else if (state == S_RUN) begin
         rem <= rem_next;
         cnt <= cnt - CW'(1);
         if (early_zero) begin
            // The remainder is exhausted, so every quotient bit still to come is zero.
            q      <= q_shift << cnt;
            sticky <= 1'b0;
         end else begin
            q <= q_shift;
            if (finish) sticky <= (rem_next != '0);
         end
      end
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_mant_div_24bit.sv
// Testbench for mant_div_24bit.
// Directed cases cover: reset, exact / repeating / max quotients, divide-by-zero,
// start ignored while busy, back-to-back starts and asynchronous abort.
// A randomized back-to-back run is checked against a reference-model scoreboard.
module tb_mant_div_24bit;

`ifdef DIV_EARLY_TERM_EN
   localparam int LAT_EXACT = 1;    // 1.0 / 1.0 : remainder zero after the first step
   localparam int LAT_MAX   = 24;   // 0xFFFFFF / 0x800000
`else
   localparam int LAT_EXACT = 26;
   localparam int LAT_MAX   = 26;
`endif
   localparam int LAT_FULL  = 26;
   localparam int MAX_WAIT  = 40;
   localparam int N_RANDOM  = 1500;

   typedef struct packed {
      logic [25:0] q;
      logic        sticky;
      logic        dz;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [23:0] a_in = '0;
   logic [23:0] b_in = '0;
   logic        busy, done, sticky, div_zero;
   logic [25:0] q;

   int n_checks = 0;
   int n_fail   = 0;
   res_t sb[$];

   mant_div_24bit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a_in),
      .b        (b_in),
      .busy     (busy),
      .done     (done),
      .q        (q),
      .sticky   (sticky),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
      $fatal(1, "watchdog");
   end

   function automatic res_t model(input logic [23:0] a, input logic [23:0] b);
      res_t        r;
      logic [63:0] num;
      if (b == '0) begin
         r.q = '1; r.sticky = 1'b1; r.dz = 1'b1;
      end else begin
         num      = {40'd0, a} << 25;
         r.q      = 26'(num / {40'd0, b});
         r.sticky = ((num % {40'd0, b}) != 64'd0);
         r.dz     = 1'b0;
      end
      return r;
   endfunction

   // Launches one operation starting at a negedge. It returns at the negedge where done is seen,
   // or when the wait bound expires. edges counts rising edges after the accepting edge.
   task automatic do_op(input logic [23:0] a, input logic [23:0] b,
                        output int edges, output res_t got, output bit saw_busy);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      edges    = 0;
      saw_busy = busy;
      while (!done && edges < MAX_WAIT) begin
         @(negedge clk);
         edges++;
         saw_busy |= busy;
      end
      got = {q, sticky, div_zero};
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({busy, done, q, sticky, div_zero} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b q=%h sticky=%b dz=%b, required all 0",
                  busy, done, q, sticky, div_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_directed();
      logic [23:0] ta [3] = '{24'h800000, 24'h800000, 24'hFFFFFF};
      logic [23:0] tb [3] = '{24'h800000, 24'hC00000, 24'h800000};
      logic [25:0] eq [3] = '{26'h2000000, 26'h1555555, 26'h3FFFFFC};
      logic        es [3] = '{1'b0, 1'b1, 1'b0};
      int          el [3] = '{LAT_EXACT, LAT_FULL, LAT_MAX};
      int   edges;
      res_t got;
      bit   sb_busy;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         do_op(ta[i], tb[i], edges, got, sb_busy);
         n_checks++;
         if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL dir%0d_done: got no done within %0d edges, required done", i, MAX_WAIT);
         end
         n_checks++;
         if (edges != el[i]) begin
            n_fail++;
            $display("FAIL dir%0d_latency: got %0d edges, required %0d", i, edges, el[i]);
         end
         n_checks++;
         if (got.q !== eq[i] || got.sticky !== es[i] || got.dz !== 1'b0) begin
            n_fail++;
            $display("FAIL dir%0d_result: got q=%h sticky=%b dz=%b, required q=%h sticky=%b dz=0",
                     i, got.q, got.sticky, got.dz, eq[i], es[i]);
         end
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || q !== eq[i] || sticky !== es[i]) begin
            n_fail++;
            $display("FAIL dir%0d_hold: got done=%b q=%h sticky=%b, required done=0 q=%h sticky=%b",
                     i, done, q, sticky, eq[i], es[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      int   edges;
      res_t got;
      bit   saw_busy;
      @(negedge clk);
      do_op(24'hABCDEF, 24'h000000, edges, got, saw_busy);
      n_checks++;
      if (done !== 1'b1 || edges != 0) begin
         n_fail++;
         $display("FAIL dz_latency: got done=%b after %0d edges, required done after 0 edges past accept",
                  done, edges);
      end
      n_checks++;
      if (got.q !== 26'h3FFFFFF || got.sticky !== 1'b1 || got.dz !== 1'b1) begin
         n_fail++;
         $display("FAIL dz_result: got q=%h sticky=%b dz=%b, required q=3ffffff sticky=1 dz=1",
                  got.q, got.sticky, got.dz);
      end
      n_checks++;
      if (saw_busy) begin
         n_fail++;
         $display("FAIL dz_busy: got busy=1, required busy never 1");
      end
   endtask

   task automatic test_busy_ignore();
      int   edges;
      res_t got;
      bit   saw_busy;
      @(negedge clk);
      a_in  = 24'h800000;
      b_in  = 24'hC00000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      edges = 0;
      while (!done && edges < MAX_WAIT) begin
         @(negedge clk);
         edges++;
         if (edges == 10) begin
            a_in  = 24'hFFFFFF;
            b_in  = 24'hFFFFFF;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      n_checks++;
      if (done !== 1'b1 || edges != LAT_FULL) begin
         n_fail++;
         $display("FAIL ignore_latency: got done=%b after %0d edges, required done after %0d",
                  done, edges, LAT_FULL);
      end
      n_checks++;
      if (q !== 26'h1555555 || sticky !== 1'b1 || div_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_result: got q=%h sticky=%b dz=%b, required q=1555555 sticky=1 dz=0",
                  q, sticky, div_zero);
      end
      // Start asserted during the done cycle, so the second op must be accepted.
      do_op(24'h800000, 24'h800000, edges, got, saw_busy);
      n_checks++;
      if (done !== 1'b1 || edges != LAT_EXACT || got.q !== 26'h2000000 || got.sticky !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_op2: got done=%b edges=%0d q=%h sticky=%b, required done=1 edges=%0d q=2000000 sticky=0",
                  done, edges, got.q, got.sticky, LAT_EXACT);
      end
   endtask

   task automatic test_abort();
      int done_seen = 0;
      @(negedge clk);
      a_in  = 24'h800000;
      b_in  = 24'hC00000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (13) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, q, sticky, div_zero} !== 30'd0) begin
         n_fail++;
         $display("FAIL abort_outputs: got busy=%b done=%b q=%h sticky=%b dz=%b, required all 0",
                  busy, done, q, sticky, div_zero);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (MAX_WAIT) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      n_checks++;
      if (done_seen != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d cycles with done/busy, required 0", done_seen);
      end
   endtask

   task automatic test_random();
      int          edges;
      res_t        got, exp;
      bit          saw_busy;
      logic [23:0] ra, rb;
      sb.delete();
      @(negedge clk);
      for (int i = 0; i < N_RANDOM; i++) begin
         ra = {1'b1, 23'($urandom)};
         rb = {1'b1, 23'($urandom)};
         if (i == 0) rb = 24'hFFFFFF;
         if (i == 1) ra = 24'hFFFFFF;
         sb.push_back(model(ra, rb));
         // No idle gap: each new op is launched in the done cycle of the previous one.
         do_op(ra, rb, edges, got, saw_busy);
         exp = sb.pop_front();
         n_checks++;
         if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL rand%0d_done: got no done within %0d edges, required done", i, MAX_WAIT);
         end
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL rand%0d_result a=%h b=%h: got q=%h sticky=%b dz=%b, required q=%h sticky=%b dz=%b",
                     i, ra, rb, got.q, got.sticky, got.dz, exp.q, exp.sticky, exp.dz);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_busy_ignore();
      test_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
